// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal line rates and the
// parity/vote helpers used by both the transmitter and the receiver.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int MAX_FRAME  = 9;
  localparam int NUM_BAUDS  = 9;
  localparam int LEGAL_BAUDS [NUM_BAUDS] = '{
    9_600, 19_200, 38_400, 57_600, 100_000, 115_200, 230_400, 460_800, 921_600
  };

  function automatic logic baud_is_legal(input int baud);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_BAUDS; i++) begin
      if (LEGAL_BAUDS[i] == baud) ok = 1'b1;
    end
    return ok;
  endfunction

  // Even-parity bit for a frame; narrower frames are zero-extended by the caller.
  function automatic logic even_parity(input logic [MAX_FRAME-1:0] d);
    return ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/clockdiv.sv
// Tick generator: one-cycle o_tick every I_CLK_FRQ/FREQUENCY clocks while enabled.
`timescale 1ns/1ps
module clockdiv #(
  parameter int I_CLK_FRQ = 100_000_000,
  parameter int FREQUENCY = 153_600
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int DIV = (I_CLK_FRQ / FREQUENCY < 1) ? 1 : I_CLK_FRQ / FREQUENCY;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(DIV - 1));
  assign o_tick = i_en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; RST_VAL is the idle level.
`timescale 1ns/1ps
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic q1_q, q2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q1_q <= RST_VAL;
      q2_q <= RST_VAL;
    end else begin
      q1_q <= i_d;
      q2_q <= q1_q;
    end
  end

  assign o_q = q2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (LSB first, optional even parity, 1/2 stop bits).
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each mid-bit sample.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int I_CLK_FRQ = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int FRAME     = 8,
  parameter int STOP      = 1,
  parameter int OVS       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  output logic [FRAME-1:0] o_data,
  output logic             o_valid,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int TW  = $clog2(OVS);
  localparam int IW  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int MID = OVS / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LAST = MID;       // vote completes one tick after mid
`else
  localparam int START_LAST = MID - 1;
`endif

  logic rx_s, tick, bit_val;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  clockdiv #(.I_CLK_FRQ(I_CLK_FRQ), .FREQUENCY(BAUD * OVS)) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (1'b1),
    .o_tick (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rx_s};
  end

  assign bit_val = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             scnt_q, scnt_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic             pe_acc_q, pe_acc_d;
  logic             fe_acc_q, fe_acc_d;
  logic             armed_q, armed_d;
  logic [FRAME-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             fe_now;

  assign fe_now = fe_acc_q | ~bit_val;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    shift_d  = shift_q;
    pe_acc_d = pe_acc_q;
    fe_acc_d = fe_acc_q;
    armed_d  = armed_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // A held-low line after a framing error must go high once before re-arming.
          if (rx_s) armed_d = 1'b1;
          else if (armed_q) begin
            state_d = ST_START;
            tcnt_d  = '0;
          end
        end
        ST_START: begin
          if (tcnt_q == TW'(START_LAST)) begin
            tcnt_d = '0;
            if (bit_val) state_d = ST_IDLE;
            else begin
              state_d = ST_DATA;
              idx_d   = '0;
            end
          end else tcnt_d = tcnt_q + TW'(1);
        end
        ST_DATA: begin
          if (tcnt_q == TW'(OVS - 1)) begin
            tcnt_d         = '0;
            shift_d[idx_q] = bit_val;
            if (idx_q == IW'(FRAME - 1)) begin
              state_d  = (PARITY != 0) ? ST_PARITY : ST_STOP;
              scnt_d   = 1'b0;
              pe_acc_d = 1'b0;
              fe_acc_d = 1'b0;
            end else idx_d = idx_q + IW'(1);
          end else tcnt_d = tcnt_q + TW'(1);
        end
        ST_PARITY: begin
          if (tcnt_q == TW'(OVS - 1)) begin
            tcnt_d   = '0;
            pe_acc_d = bit_val ^ even_parity(MAX_FRAME'(shift_q));
            state_d  = ST_STOP;
          end else tcnt_d = tcnt_q + TW'(1);
        end
        ST_STOP: begin
          if (tcnt_q == TW'(OVS - 1)) begin
            tcnt_d = '0;
            if (scnt_q == 1'(STOP - 1)) begin
              state_d = ST_IDLE;
              valid_d = 1'b1;
              data_d  = shift_q;
              perr_d  = pe_acc_q;
              ferr_d  = fe_now;
              armed_d = ~fe_now;
            end else begin
              scnt_d   = 1'b1;
              fe_acc_d = fe_now;
            end
          end else tcnt_d = tcnt_q + TW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      idx_q    <= '0;
      scnt_q   <= 1'b0;
      shift_q  <= '0;
      pe_acc_q <= 1'b0;
      fe_acc_q <= 1'b0;
      armed_q  <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      shift_q  <= shift_d;
      pe_acc_q <= pe_acc_d;
      fe_acc_q <= fe_acc_d;
      armed_q  <= armed_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: five receiver configurations driven by a serial line model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam real BIT_NS = 160.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rx_line = '1;
  logic [4:0] v, pe, fe, bz;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [8:0] d4;
  logic [8:0] dat [0:4];

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {4'b0, d3};
  assign dat[4] = d4;

  uart_rx #(.I_CLK_FRQ(1_600_000), .BAUD(100_000), .PARITY(0), .FRAME(8), .STOP(1), .OVS(16)) u0 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[0]), .o_data(d0), .o_valid(v[0]),
    .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_busy(bz[0]));
  uart_rx #(.I_CLK_FRQ(1_600_000), .BAUD(100_000), .PARITY(1), .FRAME(8), .STOP(1), .OVS(16)) u1 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[1]), .o_data(d1), .o_valid(v[1]),
    .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_busy(bz[1]));
  uart_rx #(.I_CLK_FRQ(1_600_000), .BAUD(100_000), .PARITY(0), .FRAME(8), .STOP(2), .OVS(16)) u2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[2]), .o_data(d2), .o_valid(v[2]),
    .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_busy(bz[2]));
  uart_rx #(.I_CLK_FRQ(1_600_000), .BAUD(100_000), .PARITY(0), .FRAME(5), .STOP(1), .OVS(16)) u3 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[3]), .o_data(d3), .o_valid(v[3]),
    .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_busy(bz[3]));
  uart_rx #(.I_CLK_FRQ(1_600_000), .BAUD(100_000), .PARITY(0), .FRAME(9), .STOP(1), .OVS(16)) u4 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_line[4]), .o_data(d4), .o_valid(v[4]),
    .o_parity_err(pe[4]), .o_frame_err(fe[4]), .o_busy(bz[4]));

  int         vcnt [0:4] = '{0, 0, 0, 0, 0};
  logic [8:0] cdat [0:4];
  logic       cpe  [0:4];
  logic       cfe  [0:4];

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (v[k]) begin
        vcnt[k] <= vcnt[k] + 1;
        cdat[k] <= dat[k];
        cpe[k]  <= pe[k];
        cfe[k]  <= fe[k];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  // Drives one frame; an optional 10 ns inverted spike lands spike_ns into data bit spike_bit.
  task automatic send_frame(input int ln, input logic [8:0] d, input int nb, input int par,
                            input logic pbit, input int nstop, input logic last_stop,
                            input logic end_lvl, input real bns, input int spike_bit,
                            input real spike_ns);
    @(negedge clk);
    rx_line[ln] = 1'b0;
    #(bns);
    for (int i = 0; i < nb; i++) begin
      rx_line[ln] = d[i];
      if (i == spike_bit) begin
        #(spike_ns);
        rx_line[ln] = ~d[i];
        #10;
        rx_line[ln] = d[i];
        #(bns - spike_ns - 10.0);
      end else #(bns);
    end
    if (par != 0) begin
      rx_line[ln] = pbit;
      #(bns);
    end
    for (int s = 0; s < nstop; s++) begin
      rx_line[ln] = (s == nstop - 1) ? last_stop : 1'b1;
      #(bns);
    end
    rx_line[ln] = end_lvl;
  endtask

  task automatic expect_frame(input int k, input int n0, input string tag, input logic [8:0] ed,
                              input logic epe, input logic efe);
    int w;
    w = 0;
    while (vcnt[k] == n0 && w < 80) begin
      @(negedge clk);
      w++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_pulses"}, vcnt[k] - n0, 1);
    check({tag, "_data"}, cdat[k], ed);
    check({tag, "_perr"}, cpe[k], epe);
    check({tag, "_ferr"}, cfe[k], efe);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, bcnt, lim;
    rst = 1'b1;
    rx_line = '1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", v[0], 0);
    check("rst_busy", bz, 0);
    check("rst_data", d0, 0);
    check("rst_perr", pe[0], 0);
    check("rst_ferr", fe[0], 0);
    idle_bits(1);

    // Plain 8N1 frames.
    n0 = vcnt[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS, -1, 0.0);
    expect_frame(0, n0, "lb_a5", 9'h0A5, 1'b0, 1'b0);
    n0 = vcnt[0];
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS, -1, 0.0);
    expect_frame(0, n0, "lb_3c", 9'h03C, 1'b0, 1'b0);

    // Even parity: 0x0F has four ones, so the correct parity bit is 0.
    n0 = vcnt[1];
    send_frame(1, 9'h00F, 8, 1, 1'b1, 1, 1'b1, 1'b1, BIT_NS, -1, 0.0);
    expect_frame(1, n0, "par_bad", 9'h00F, 1'b1, 1'b0);
    n0 = vcnt[1];
    send_frame(1, 9'h00F, 8, 1, 1'b0, 1, 1'b1, 1'b1, BIT_NS, -1, 0.0);
    expect_frame(1, n0, "par_good", 9'h00F, 1'b0, 1'b0);

    // Second stop bit low, then a 40-bit break: exactly one errored frame.
    n0 = vcnt[2];
    send_frame(2, 9'h05A, 8, 0, 1'b0, 2, 1'b0, 1'b0, BIT_NS, -1, 0.0);
    expect_frame(2, n0, "brk", 9'h05A, 1'b0, 1'b1);
    n0 = vcnt[2];
    idle_bits(40);
    check("brk_hold_pulses", vcnt[2] - n0, 0);
    check("brk_hold_busy", bz[2], 0);
    rx_line[2] = 1'b1;
    idle_bits(2);
    n0 = vcnt[2];
    send_frame(2, 9'h033, 8, 0, 1'b0, 2, 1'b1, 1'b1, BIT_NS, -1, 0.0);
    expect_frame(2, n0, "brk_rec", 9'h033, 1'b0, 1'b0);

    // 4-clock glitch on an idle line.
    n0 = vcnt[0];
    bcnt = 0;
`ifdef UART_RX_MAJORITY_EN
    lim = 9;
`else
    lim = 8;
`endif
    @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bz[0]) bcnt++;
    end
    rx_line[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bz[0]) bcnt++;
    end
    check("glitch_busy_seen", (bcnt > 0), 1);
    check("glitch_busy_short", (bcnt <= lim), 1);
    check("glitch_busy_end", bz[0], 0);
    check("glitch_pulses", vcnt[0] - n0, 0);

    // Reset during data bit 3 of 0x96 (bit 3 is 0).
    idle_bits(1);
    n0 = vcnt[0];
    rx_line[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (32) @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx_line[0] = 1'b1;
    @(negedge clk);
    check("midrst_valid", v[0], 0);
    check("midrst_busy", bz[0], 0);
    check("midrst_data", d0, 0);
    check("midrst_flags", {pe[0], fe[0]}, 0);
    rst = 1'b0;
    idle_bits(3);
    check("midrst_pulses", vcnt[0] - n0, 0);
    n0 = vcnt[0];
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS, -1, 0.0);
    expect_frame(0, n0, "midrst_55", 9'h055, 1'b0, 1'b0);

    // Frame widths 5 and 9 with +/-3% driver skew.
    n0 = vcnt[3];
    send_frame(3, 9'h015, 5, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS * 1.03, -1, 0.0);
    expect_frame(3, n0, "f5_slow", 9'h015, 1'b0, 1'b0);
    n0 = vcnt[3];
    send_frame(3, 9'h015, 5, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS * 0.97, -1, 0.0);
    expect_frame(3, n0, "f5_fast", 9'h015, 1'b0, 1'b0);
    n0 = vcnt[4];
    send_frame(4, 9'h1AB, 9, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS * 1.03, -1, 0.0);
    expect_frame(4, n0, "f9_slow", 9'h1AB, 1'b0, 1'b0);
    n0 = vcnt[4];
    send_frame(4, 9'h1AB, 9, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS * 0.97, -1, 0.0);
    expect_frame(4, n0, "f9_fast", 9'h1AB, 1'b0, 1'b0);

    // Spike well away from the sample point is ignored by every build.
    n0 = vcnt[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS, 2, 40.0);
    expect_frame(0, n0, "spike_off", 9'h0A5, 1'b0, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    n0 = vcnt[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT_NS, 5, 80.0);
    expect_frame(0, n0, "spike_mid", 9'h0A5, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
